// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// uart_rx_oversampled : 16x-oversampled UART receiver with majority voting,
// optional parity, framing-error and break detection.      Rev 1.0
// ============================================================================
module uart_rx_oversampled #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 os_tick,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 rx_busy
);

  localparam int c_tick_w = $clog2(OVERSAMPLE);
  localparam int c_bit_w  = $clog2(DATA_BITS);
  localparam logic [c_tick_w-1:0] c_mid_m1   = c_tick_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_tick_w-1:0] c_mid      = c_tick_w'(OVERSAMPLE / 2);
  localparam logic [c_tick_w-1:0] c_mid_p1   = c_tick_w'(OVERSAMPLE / 2 + 1);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
  localparam logic [c_bit_w-1:0]  c_bit_last = c_bit_w'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_tick_w-1:0]    r_tick_cnt;
  logic [c_bit_w-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_samp_a;
  logic                   r_samp_b;
  logic                   r_par_en;
  logic                   r_par_odd;
  logic                   r_par_flag;
  logic                   r_par_bit;
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rx_valid;
  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   r_break_det;

  logic w_rx_s;
  logic w_maj;
  logic w_decide;
  logic w_bit_end;

  assign w_rx_s    = r_sync[SYNC_STAGES-1];
  assign w_maj     = (r_samp_a & r_samp_b) | (r_samp_a & w_rx_s) | (r_samp_b & w_rx_s);
  assign w_decide  = os_tick && (r_tick_cnt == c_mid_p1);
  assign w_bit_end = os_tick && (r_tick_cnt == c_tick_last);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (os_tick && !w_rx_s) w_next = ST_START;
      ST_START: begin
        if (w_decide && w_maj) w_next = ST_IDLE;
        else if (w_bit_end)    w_next = ST_DATA;
      end
      ST_DATA:      if (w_bit_end && (r_bit_idx == c_bit_last))
                      w_next = r_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (w_bit_end) w_next = ST_STOP;
      // Leaving at mid-stop lets an immediately following start edge be caught
      ST_STOP:      if (w_decide) w_next = w_maj ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (os_tick && w_rx_s) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync       <= '1;
      r_tick_cnt   <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_samp_a     <= 1'b1;
      r_samp_b     <= 1'b1;
      r_par_en     <= 1'b0;
      r_par_odd    <= 1'b0;
      r_par_flag   <= 1'b0;
      r_par_bit    <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_break_det  <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], rx};
      r_rx_valid <= 1'b0;
      if (os_tick) begin
        if (r_state == ST_IDLE || r_state == ST_WAIT_HIGH || w_next != r_state ||
            r_tick_cnt == c_tick_last)
          r_tick_cnt <= '0;
        else
          r_tick_cnt <= r_tick_cnt + 1'b1;

        if (r_tick_cnt == c_mid_m1) r_samp_a <= w_rx_s;
        if (r_tick_cnt == c_mid)    r_samp_b <= w_rx_s;

        if (r_state == ST_START)
          r_bit_idx <= '0;
        else if (r_state == ST_DATA && r_tick_cnt == c_tick_last)
          r_bit_idx <= r_bit_idx + 1'b1;

        // Frame configuration is frozen from the start-edge tick onward
        if (r_state == ST_IDLE) begin
          r_par_en   <= parity_en;
          r_par_odd  <= parity_odd;
          r_par_flag <= 1'b0;
          r_par_bit  <= 1'b0;
        end

        if (w_decide) begin
          case (r_state)
            ST_DATA:   r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            ST_PARITY: begin
              r_par_bit  <= w_maj;
              r_par_flag <= w_maj ^ (^r_shift) ^ r_par_odd;
            end
            ST_STOP: begin
              r_rx_data    <= r_shift;
              r_rx_valid   <= 1'b1;
              r_frame_err  <= ~w_maj;
              r_parity_err <= r_par_en & r_par_flag;
              r_break_det  <= ~w_maj && (r_shift == '0) && !(r_par_en && r_par_bit);
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign break_det  = r_break_det;
  assign rx_busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_oversampled : directed self-checking bench for uart_rx_oversampled.
// Rev 1.0
// ============================================================================
module tb_uart_rx_oversampled;

  localparam int c_bit_clks = 64;  // 16 os_ticks x 4 clk

  logic       clk = 1'b0;
  logic       reset;
  logic       os_tick;
  logic       rx;
  logic       parity_en;
  logic       parity_odd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;
  logic       rx_busy;

  logic [1:0] r_div = 2'd0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         valid_cnt = 0;
  int         base;
  logic [7:0] cap_data [0:63];
  logic       r_prev_valid = 1'b0;

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .os_tick    (os_tick),
    .rx         (rx),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) r_div <= r_div + 2'd1;
  assign os_tick = (r_div == 2'd3);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record every rx_valid pulse and confirm it lasts a single clock
  always @(negedge clk) begin
    if (rx_valid) begin
      if (valid_cnt < 64) cap_data[valid_cnt] = rx_data;
      valid_cnt++;
      check("valid_pulse_width", {31'd0, r_prev_valid}, 32'd0);
    end
    r_prev_valid = rx_valid;
  end

  task automatic bit_time(input logic b);
    rx = b;
    repeat (c_bit_clks) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par,
                            input logic par_bit, input logic stop_bit);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (with_par) bit_time(par_bit);
    bit_time(stop_bit);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) bit_time(1'b1);
  endtask

  initial begin
    reset      = 1'b1;
    rx         = 1'b1;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_break_det", {31'd0, break_det}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    idle_bits(2);

    // 8N1 0xA5
    base = valid_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle_bits(2);
    check("t1_valid_count", valid_cnt - base, 32'd1);
    check("t1_rx_data", {24'd0, rx_data}, 32'hA5);
    check("t1_parity_err", {31'd0, parity_err}, 32'd0);
    check("t1_frame_err", {31'd0, frame_err}, 32'd0);
    check("t1_break_det", {31'd0, break_det}, 32'd0);
    check("t1_rx_busy", {31'd0, rx_busy}, 32'd0);

    // False start: 4 os_ticks low
    base = valid_cnt;
    rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rx = 1'b1;
    check("t2_busy_after_edge", {31'd0, rx_busy}, 32'd1);
    idle_bits(2);
    check("t2_no_valid", valid_cnt - base, 32'd0);
    check("t2_busy_cleared", {31'd0, rx_busy}, 32'd0);

    // Even parity, 0x3C (four ones) sent with parity bit 1 -> mismatch
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    base = valid_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    idle_bits(2);
    check("t3_valid_count", valid_cnt - base, 32'd1);
    check("t3_rx_data", {24'd0, rx_data}, 32'h3C);
    check("t3_parity_err", {31'd0, parity_err}, 32'd1);
    check("t3_frame_err", {31'd0, frame_err}, 32'd0);

    // Odd parity, 0x07 (three ones) with parity bit 0 -> correct
    parity_odd = 1'b1;
    base = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    idle_bits(2);
    check("t3b_valid_count", valid_cnt - base, 32'd1);
    check("t3b_rx_data", {24'd0, rx_data}, 32'h07);
    check("t3b_parity_err", {31'd0, parity_err}, 32'd0);
    parity_en  = 1'b0;
    parity_odd = 1'b0;

    // Framing error then a clean frame
    base = valid_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    idle_bits(2);
    check("t4_valid_count", valid_cnt - base, 32'd1);
    check("t4_rx_data", {24'd0, rx_data}, 32'h55);
    check("t4_frame_err", {31'd0, frame_err}, 32'd1);
    check("t4_break_det", {31'd0, break_det}, 32'd0);
    check("t4_parity_err", {31'd0, parity_err}, 32'd0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    idle_bits(2);
    check("t4_next_count", valid_cnt - base, 32'd2);
    check("t4_next_data", {24'd0, rx_data}, 32'h12);
    check("t4_next_frame_err", {31'd0, frame_err}, 32'd0);

    // Break: rx low for 3 frame times
    base = valid_cnt;
    for (int i = 0; i < 30; i++) bit_time(1'b0);
    check("t5_valid_count", valid_cnt - base, 32'd1);
    check("t5_rx_data", {24'd0, rx_data}, 32'h00);
    check("t5_frame_err", {31'd0, frame_err}, 32'd1);
    check("t5_break_det", {31'd0, break_det}, 32'd1);
    check("t5_busy_in_break", {31'd0, rx_busy}, 32'd1);
    idle_bits(2);
    check("t5_count_after_high", valid_cnt - base, 32'd1);
    check("t5_busy_cleared", {31'd0, rx_busy}, 32'd0);

    // Reset during data bit 3 of 0xFF
    base = valid_cnt;
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(1'b1);
    rx = 1'b1;
    repeat (c_bit_clks / 2) @(posedge clk);
    #1;
    check("t6_busy_before_reset", {31'd0, rx_busy}, 32'd1);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_rx_data", {24'd0, rx_data}, 32'h00);
    check("t6_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("t6_frame_err", {31'd0, frame_err}, 32'd0);
    check("t6_break_det", {31'd0, break_det}, 32'd0);
    check("t6_parity_err", {31'd0, parity_err}, 32'd0);
    idle_bits(12);
    check("t6_no_valid", valid_cnt - base, 32'd0);

    // Back-to-back frames with a single stop bit
    base = valid_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    idle_bits(2);
    check("t6_b2b_count", valid_cnt - base, 32'd2);
    if (valid_cnt - base == 2) begin
      check("t6_b2b_first", {24'd0, cap_data[base]}, 32'h00);
      check("t6_b2b_second", {24'd0, cap_data[base+1]}, 32'hFF);
    end
    check("t6_b2b_frame_err", {31'd0, frame_err}, 32'd0);
    check("t6_b2b_break_det", {31'd0, break_det}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
